// File: rtl/tiger_muldiv.sv
`default_nettype none
// ============================================================================
// tiger_muldiv : iterative radix-2 MULT/MULTU/DIV/DIVU unit with HI/LO regs
// Revision     : 1.0
// ============================================================================
module tiger_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   count;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   dvd_orig;
  logic               is_div;
  logic               neg_q;
  logic               neg_r;
  logic               div_zero;

  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH:0]   div_shift;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] acc_step;
  logic [2*WIDTH-1:0] mul_signed;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  // Signed ops run on magnitudes; op[0]=0 selects the signed variants.
  always_comb begin
    a_neg = ~op[0] & srca[WIDTH-1];
    b_neg = ~op[0] & srcb[WIDTH-1];
    a_mag = a_neg ? -srca : srca;
    b_mag = b_neg ? -srcb : srcb;
  end

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    div_shift = {acc, 1'b0};
    div_trial = div_shift[2*WIDTH:WIDTH] - {1'b0, opnd};
    if (!is_div) begin
      acc_step = {mul_sum, acc[WIDTH-1:1]};
    end else if (div_trial[WIDTH]) begin
      acc_step = div_shift[2*WIDTH-1:0];
    end else begin
      acc_step = {div_trial[WIDTH-1:0], div_shift[WIDTH-1:1], 1'b1};
    end
  end

  // Final sign correction applied to the last step so hi/lo land with done.
  always_comb begin
    mul_signed = neg_q ? -acc_step : acc_step;
    res_hi     = mul_signed[2*WIDTH-1:WIDTH];
    res_lo     = mul_signed[WIDTH-1:0];
    if (is_div) begin
      if (div_zero) begin
        res_hi = dvd_orig;
        res_lo = {WIDTH{1'b1}};
      end else begin
        res_lo = neg_q ? -acc_step[WIDTH-1:0] : acc_step[WIDTH-1:0];
        res_hi = neg_r ? -acc_step[2*WIDTH-1:WIDTH] : acc_step[2*WIDTH-1:WIDTH];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && !op[2]) state_nxt = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (count == LAST) state_nxt = S_FIN;
      end
      S_FIN: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      count    <= '0;
      acc      <= '0;
      opnd     <= '0;
      dvd_orig <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (start && !op[2]) begin
            count    <= '0;
            is_div   <= op[1];
            opnd     <= op[1] ? b_mag : a_mag;
            acc      <= {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            div_zero <= op[1] && (srcb == '0);
            dvd_orig <= srca;
          end else if (start && op == 3'b100) begin
            hi <= srca;
          end else if (start && op == 3'b101) begin
            lo <= srca;
          end
        end
        S_RUN: begin
          acc   <= acc_step;
          count <= count + CNT_W'(1);
          if (count == LAST) begin
            hi <= res_hi;
            lo <= res_lo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tiger_muldiv.sv
`default_nettype none
// ============================================================================
// tb_tiger_muldiv : randomized + directed self-checking bench for tiger_muldiv
// Revision        : 1.0
// ============================================================================
module tb_tiger_muldiv;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] srca;
  logic [31:0] srcb;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] m_hi = 32'h0;
  logic [31:0] m_lo = 32'h0;

  tiger_muldiv #(.WIDTH(32), .CNT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .srca  (srca),
    .srcb  (srcb),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Architectural result {hi, lo} from plain arithmetic.
  function automatic logic [63:0] ref_model(input logic [2:0] o, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] h,
                                            input logic [31:0] l);
    longint      sp;
    logic [63:0] up;
    int          sq;
    int          sr;
    case (o)
      3'd0: begin sp = longint'($signed(a)) * longint'($signed(b)); return sp; end
      3'd1: begin up = {32'd0, a} * {32'd0, b}; return up; end
      3'd2: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        sq = $signed(a) / $signed(b);
        sr = $signed(a) % $signed(b);
        return {sr, sq};
      end
      3'd3: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      3'd4: return {a, l};
      3'd5: return {h, a};
      default: return {h, l};
    endcase
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = o; srca = a; srcb = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Sample index 0 is just after the start edge; done is expected at index 32.
  task automatic wait_done(output int lat, output bit busy_ok, output bit hold_ok);
    lat = -1; busy_ok = 1'b1; hold_ok = 1'b1;
    for (int k = 0; k <= 40; k++) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (k < 32 && (hi !== m_hi || lo !== m_lo)) hold_ok = 1'b0;
      if (done === 1'b1) begin
        lat = k;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = 3'd0; srca = 32'h0; srcb = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b hi=%h lo=%h expected 0 0 0 0", busy, done, hi, lo);
    end
    @(negedge clk);
    reset = 1'b0;
    m_hi = 32'h0; m_lo = 32'h0;
  endtask

  task automatic test_mthi_mtlo();
    @(negedge clk);
    start = 1'b1; op = 3'b100; srca = 32'hAAAA_5555; srcb = 32'h0;
    @(posedge clk); #1;
    checks++;
    if (hi !== 32'hAAAA_5555 || lo !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL mthi: hi=%h lo=%h busy=%b done=%b expected AAAA5555 00000000 0 0", hi, lo, busy, done);
    end
    op = 3'b101; srca = 32'h1234_ABCD;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (hi !== 32'hAAAA_5555 || lo !== 32'h1234_ABCD || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL mtlo: hi=%h lo=%h busy=%b done=%b expected AAAA5555 1234ABCD 0 0", hi, lo, busy, done);
    end
    m_hi = 32'hAAAA_5555; m_lo = 32'h1234_ABCD;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL mtxx_quiet: busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_mult_latency();
    int lat; bit bok; bit hok;
    issue(3'd0, 32'hFFFF_FFFD, 32'd7);
    wait_done(lat, bok, hok);
    checks++;
    if (lat != 32 || !bok || !hok) begin
      errors++;
      $display("FAIL mult_latency: done_at=%0d busy_ok=%0d hold_ok=%0d expected 32 1 1", lat, bok, hok);
    end
    checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB) begin
      errors++;
      $display("FAIL mult_result: hi=%h lo=%h expected FFFFFFFF FFFFFFEB", hi, lo);
    end
    m_hi = 32'hFFFF_FFFF; m_lo = 32'hFFFF_FFEB;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL mult_release: busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_directed();
    logic [2:0]  t_op [8] = '{3'd1, 3'd0, 3'd2, 3'd3, 3'd2, 3'd3, 3'd2, 3'd2};
    logic [31:0] t_a  [8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd100,
                              32'h8000_0000, 32'h1234_5678, 32'h8000_0001, 32'd7};
    logic [31:0] t_b  [8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd7,
                              32'hFFFF_FFFF, 32'd0, 32'd0, 32'hFFFF_FFFE};
    logic [31:0] t_hi [8] = '{32'hFFFF_FFFE, 32'h0, 32'hFFFF_FFFF, 32'd2,
                              32'h0, 32'h1234_5678, 32'h8000_0001, 32'd1};
    logic [31:0] t_lo [8] = '{32'h1, 32'h1, 32'hFFFF_FFFD, 32'h0E,
                              32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    int lat; bit bok; bit hok;
    for (int i = 0; i < 8; i++) begin
      issue(t_op[i], t_a[i], t_b[i]);
      wait_done(lat, bok, hok);
      checks++;
      if (lat != 32 || !bok || !hok || hi !== t_hi[i] || lo !== t_lo[i]) begin
        errors++;
        $display("FAIL directed[%0d]: op=%0d a=%h b=%h got hi=%h lo=%h done_at=%0d busy_ok=%0d hold_ok=%0d expected hi=%h lo=%h done_at=32",
                 i, t_op[i], t_a[i], t_b[i], hi, lo, lat, bok, hok, t_hi[i], t_lo[i]);
      end
      m_hi = t_hi[i]; m_lo = t_lo[i];
      @(posedge clk); #1;
    end
  endtask

  task automatic test_start_held();
    int  done_cnt = 0;
    int  done_at = -1;
    bit  hok = 1'b1;
    bit  bok = 1'b1;
    @(negedge clk);
    start = 1'b1; op = 3'd1; srca = 32'd2; srcb = 32'd3;
    @(posedge clk); #1;
    op = 3'b100; srca = 32'd9; srcb = 32'd9;
    for (int k = 0; k < 40; k++) begin
      if (k == 4) start = 1'b0;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
      if (k <= 32 && busy !== 1'b1) bok = 1'b0;
      if (k > 33 && busy !== 1'b0) bok = 1'b0;
      if (k < 32 && (hi !== m_hi || lo !== m_lo)) hok = 1'b0;
      @(posedge clk); #1;
    end
    checks++;
    if (done_cnt != 1 || done_at != 32 || !bok || !hok) begin
      errors++;
      $display("FAIL start_held: done_count=%0d done_at=%0d busy_ok=%0d hold_ok=%0d expected 1 32 1 1",
               done_cnt, done_at, bok, hok);
    end
    checks++;
    if (hi !== 32'h0 || lo !== 32'd6) begin
      errors++;
      $display("FAIL start_held_result: hi=%h lo=%h expected 00000000 00000006", hi, lo);
    end
    m_hi = 32'h0; m_lo = 32'd6;
  endtask

  task automatic test_back_to_back();
    int lat; bit bok; bit hok;
    issue(3'd3, 32'd1000, 32'd10);
    wait_done(lat, bok, hok);
    checks++;
    if (lat != 32 || hi !== 32'd0 || lo !== 32'd100) begin
      errors++;
      $display("FAIL b2b_first: hi=%h lo=%h done_at=%0d expected 00000000 00000064 32", hi, lo, lat);
    end
    m_hi = 32'd0; m_lo = 32'd100;
    @(negedge clk);
    start = 1'b1; op = 3'd0; srca = 32'hFFFF_FFFB; srcb = 32'd6;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_fin_ignore: busy=%b done=%b expected 0 0", busy, done);
    end
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat, bok, hok);
    checks++;
    if (lat != 32 || !bok || !hok || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFE2) begin
      errors++;
      $display("FAIL b2b_second: hi=%h lo=%h done_at=%0d busy_ok=%0d hold_ok=%0d expected FFFFFFFF FFFFFFE2 32 1 1",
               hi, lo, lat, bok, hok);
    end
    m_hi = 32'hFFFF_FFFF; m_lo = 32'hFFFF_FFE2;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midrun();
    int lat; bit bok; bit hok;
    issue(3'd2, 32'd1000, 32'd7);
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      errors++;
      $display("FAIL reset_midrun: busy=%b done=%b hi=%h lo=%h expected 0 0 0 0", busy, done, hi, lo);
    end
    m_hi = 32'h0; m_lo = 32'h0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b done=%b expected 0 0", busy, done);
    end
    issue(3'd3, 32'd1000, 32'd7);
    wait_done(lat, bok, hok);
    checks++;
    if (lat != 32 || !bok || !hok || hi !== 32'd6 || lo !== 32'd142) begin
      errors++;
      $display("FAIL reset_restart: hi=%h lo=%h done_at=%0d busy_ok=%0d hold_ok=%0d expected 00000006 0000008E 32 1 1",
               hi, lo, lat, bok, hok);
    end
    m_hi = 32'd6; m_lo = 32'd142;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int          lat; bit bok; bit hok;
    logic [2:0]  o;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    for (int i = 0; i < 60; i++) begin
      o   = 3'($urandom_range(0, 7));
      a   = pick_operand();
      b   = pick_operand();
      exp = ref_model(o, a, b, m_hi, m_lo);
      issue(o, a, b);
      if (!o[2]) begin
        wait_done(lat, bok, hok);
        checks++;
        if (lat != 32 || !bok || !hok || hi !== exp[63:32] || lo !== exp[31:0]) begin
          errors++;
          $display("FAIL random[%0d]: op=%0d a=%h b=%h got hi=%h lo=%h done_at=%0d busy_ok=%0d hold_ok=%0d expected hi=%h lo=%h done_at=32",
                   i, o, a, b, hi, lo, lat, bok, hok, exp[63:32], exp[31:0]);
        end
        @(posedge clk); #1;
      end else begin
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== exp[63:32] || lo !== exp[31:0]) begin
          errors++;
          $display("FAIL random[%0d]: op=%0d a=%h got hi=%h lo=%h busy=%b done=%b expected hi=%h lo=%h busy=0 done=0",
                   i, o, a, hi, lo, busy, done, exp[63:32], exp[31:0]);
        end
      end
      m_hi = exp[63:32];
      m_lo = exp[31:0];
    end
  endtask

  initial begin
    test_reset();
    test_mthi_mtlo();
    test_mult_latency();
    test_directed();
    test_start_held();
    test_back_to_back();
    test_reset_midrun();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
